// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl: run controller between the simulation bench and the CPU top.
// Sequences the CPU reset, counts RUN cycles, and ends a run on a halt
// request or when the cycle budget is spent, reporting how and where it ended.
//
// Optional build macro: SIM_RUN_CTRL_STALL_DETECT_EN
//   When defined, a PC that stays unchanged for HALT_STABLE consecutive RUN
//   cycles ends the run exactly like halt_req (catches `j .` self-loops).
//
// Ports:
//   clk        in   1      system clock, rising edge
//   rst        in   1      synchronous active-high reset
//   start      in   1      pulse; begins a run from IDLE or DONE
//   halt_req   in   1      CPU halt indication, sampled in RUN
//   pc         in   PC_W   current CPU PC
//   cpu_rst    out  1      reset to the CPU; low only while running
//   running    out  1      high while in RUN
//   done       out  1      high while in DONE
//   timeout    out  1      valid with done; 1 = budget exhausted, 0 = halted
//   cycle_cnt  out  CYC_W  RUN cycles executed in the current/last run
//   final_pc   out  PC_W   pc sampled on the exit cycle of RUN
module sim_run_ctrl #(
  parameter int unsigned RST_CYCLES  = 25,
  parameter int unsigned MAX_CYCLES  = 1500,
  parameter int unsigned CYC_W       = 32,
  parameter int unsigned PC_W        = 32,
  parameter int unsigned AUTO_START  = 1,
  parameter int unsigned HALT_STABLE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt_req,
  input  logic [PC_W-1:0]  pc,
  output logic             cpu_rst,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CYC_W-1:0] cycle_cnt,
  output logic [PC_W-1:0]  final_pc
);

  localparam int unsigned RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  // Reject configurations the counters cannot represent.
  if (RST_CYCLES < 1 || MAX_CYCLES < 1 || HALT_STABLE < 2) begin : g_bad_param
    $error("sim_run_ctrl: RST_CYCLES/MAX_CYCLES must be >=1, HALT_STABLE >=2");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state, state_d;
  logic             auto_arm, auto_arm_d;
  logic [RC_W-1:0]  rst_cnt, rst_cnt_d;
  logic [CYC_W-1:0] cycle_cnt_d;
  logic             timeout_d;
  logic [PC_W-1:0]  final_pc_d;
  logic             stop_req;

`ifdef SIM_RUN_CTRL_STALL_DETECT_EN
  localparam int unsigned ST_W = $clog2(HALT_STABLE + 1);

  logic [PC_W-1:0]  prev_pc, prev_pc_d;
  logic [ST_W-1:0]  stable, stable_d;
  logic             stall_hit;

  // Track how long pc has been frozen; the first RUN cycle only seeds prev_pc.
  always_comb begin
    prev_pc_d = prev_pc;
    stable_d  = stable;
    stall_hit = 1'b0;
    if (state == ST_RUN) begin
      prev_pc_d = pc;
      if (cycle_cnt == '0) begin
        stable_d = '0;
      end else if (pc == prev_pc) begin
        stable_d = stable + ST_W'(1);
        // This increment reaches HALT_STABLE-1: HALT_STABLE equal PCs seen.
        if (stable == ST_W'(HALT_STABLE - 2)) begin
          stall_hit = 1'b1;
        end
      end else begin
        stable_d = '0;
      end
    end else if (state_d == ST_RESET) begin
      prev_pc_d = '0;
      stable_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_pc <= '0;
      stable  <= '0;
    end else begin
      prev_pc <= prev_pc_d;
      stable  <= stable_d;
    end
  end

  assign stop_req = halt_req | stall_hit;
`else
  assign stop_req = halt_req;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state;
    auto_arm_d  = auto_arm;
    rst_cnt_d   = rst_cnt;
    cycle_cnt_d = cycle_cnt;
    timeout_d   = timeout;
    final_pc_d  = final_pc;

    unique case (state)
      ST_IDLE: begin
        if (start || auto_arm) begin
          state_d     = ST_RESET;
          auto_arm_d  = 1'b0;
          rst_cnt_d   = '0;
          cycle_cnt_d = '0;
          timeout_d   = 1'b0;
        end
      end

      ST_RESET: begin
        rst_cnt_d = rst_cnt + RC_W'(1);
        if (rst_cnt == RC_W'(RST_CYCLES - 1)) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        // The exit cycle is counted too, so a timeout ends at MAX_CYCLES.
        cycle_cnt_d = cycle_cnt + CYC_W'(1);
        if (stop_req) begin
          state_d    = ST_DONE;
          timeout_d  = 1'b0;
          final_pc_d = pc;
        end else if (cycle_cnt == CYC_W'(MAX_CYCLES - 1)) begin
          state_d    = ST_DONE;
          timeout_d  = 1'b1;
          final_pc_d = pc;
        end
      end

      ST_DONE: begin
        if (start) begin
          state_d     = ST_RESET;
          rst_cnt_d   = '0;
          cycle_cnt_d = '0;
          timeout_d   = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; status flags follow the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      auto_arm  <= (AUTO_START != 0);
      rst_cnt   <= '0;
      cycle_cnt <= '0;
      timeout   <= 1'b0;
      final_pc  <= '0;
      cpu_rst   <= 1'b1;
      running   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      auto_arm  <= auto_arm_d;
      rst_cnt   <= rst_cnt_d;
      cycle_cnt <= cycle_cnt_d;
      timeout   <= timeout_d;
      final_pc  <= final_pc_d;
      cpu_rst   <= (state_d != ST_RUN);
      running   <= (state_d == ST_RUN);
      done      <= (state_d == ST_DONE);
    end
  end

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Bench for sim_run_ctrl: one auto-start instance driven from a vector table,
// one manual-start instance driven by hand-written sequences.
module tb_sim_run_ctrl;

  localparam int unsigned RST = 4;
  localparam int unsigned MAX = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, halt_a, start_m, halt_m;
  logic [31:0] pc_a, pc_m;
  logic        cpu_rst_a, running_a, done_a, timeout_a;
  logic        cpu_rst_m, running_m, done_m, timeout_m;
  logic [31:0] cycle_cnt_a, final_pc_a, cycle_cnt_m, final_pc_m;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sim_run_ctrl #(.RST_CYCLES(RST), .MAX_CYCLES(MAX), .CYC_W(32), .PC_W(32),
                 .AUTO_START(1), .HALT_STABLE(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .halt_req(halt_a), .pc(pc_a),
    .cpu_rst(cpu_rst_a), .running(running_a), .done(done_a),
    .timeout(timeout_a), .cycle_cnt(cycle_cnt_a), .final_pc(final_pc_a));

  sim_run_ctrl #(.RST_CYCLES(RST), .MAX_CYCLES(MAX), .CYC_W(32), .PC_W(32),
                 .AUTO_START(0), .HALT_STABLE(4)) dut_m (
    .clk(clk), .rst(rst), .start(start_m), .halt_req(halt_m), .pc(pc_m),
    .cpu_rst(cpu_rst_m), .running(running_m), .done(done_m),
    .timeout(timeout_m), .cycle_cnt(cycle_cnt_m), .final_pc(final_pc_m));

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Hold rst for two edges, check reset outputs, release at a negedge.
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_cpu_rst", 64'(cpu_rst_a), 64'd1);
    check("rst_running", 64'(running_a), 64'd0);
    check("rst_done",    64'(done_a),    64'd0);
    check("rst_cnt",     64'(cycle_cnt_a), 64'd0);
    check("rst_fpc",     64'(final_pc_a),  64'd0);
    rst = 1'b0;
  endtask

  // Count cycles with cpu_rst high up to the first RUN cycle (bounded).
  task automatic count_cpu_rst_a(output int n);
    n = 0;
    while (cpu_rst_a && n < 60) begin
      n++;
      @(negedge clk);
    end
  endtask

  typedef struct {
    string       name;
    int          halt_at;
    logic [31:0] halt_pc;
    int          hold_from;
    logic        exp_to;
    int          exp_cnt;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n;
    int k;
    rst = 1'b1; start_a = 1'b0; halt_a = 1'b0; pc_a = '0;
    start_m = 1'b0; halt_m = 1'b0; pc_m = '0;

    vecs[0] = '{"halt10",  10, 32'h40,  0, 1'b0, 10, 32'h40};
    vecs[1] = '{"tmo",      0, 32'h0,   0, 1'b1, 20, 32'h4C};
    vecs[2] = '{"halt_end",20, 32'h99C, 0, 1'b0, 20, 32'h99C};
    vecs[3] = '{"halt1",    1, 32'h10,  0, 1'b0,  1, 32'h10};
    vecs[4] = '{"halt19",  19, 32'h48,  0, 1'b0, 19, 32'h48};
`ifdef SIM_RUN_CTRL_STALL_DETECT_EN
    vecs[5] = '{"stall",    0, 32'h0,   6, 1'b0,  9, 32'h88};
`else
    vecs[5] = '{"stall",    0, 32'h0,   6, 1'b1, 20, 32'h88};
`endif

    // Table-driven auto-start runs.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      count_cpu_rst_a(n);
      check({vecs[v].name, "_rst_len"}, 64'(n), 64'(RST + 1));
      check({vecs[v].name, "_running"}, 64'(running_a), 64'd1);
      k = 0;
      while (running_a && k < 100) begin
        k++;
        if (k == vecs[v].halt_at)
          pc_a = vecs[v].halt_pc;
        else if (vecs[v].hold_from > 0 && k >= vecs[v].hold_from)
          pc_a = 32'h88;
        else
          pc_a = 32'(4 * (k - 1));
        halt_a = (k == vecs[v].halt_at);
        @(negedge clk);
      end
      halt_a = 1'b0;
      check({vecs[v].name, "_run_len"}, 64'(k), 64'(vecs[v].exp_cnt));
      check({vecs[v].name, "_done"},    64'(done_a), 64'd1);
      check({vecs[v].name, "_cpu_rst"}, 64'(cpu_rst_a), 64'd1);
      check({vecs[v].name, "_timeout"}, 64'(timeout_a), 64'(vecs[v].exp_to));
      check({vecs[v].name, "_cnt"},     64'(cycle_cnt_a), 64'(vecs[v].exp_cnt));
      check({vecs[v].name, "_fpc"},     64'(final_pc_a), 64'(vecs[v].exp_pc));
      repeat (3) @(negedge clk);
      check({vecs[v].name, "_hold_done"}, 64'(done_a), 64'd1);
      check({vecs[v].name, "_hold_cnt"},  64'(cycle_cnt_a), 64'(vecs[v].exp_cnt));
    end

    // rst asserted on the 7th RUN cycle, then auto-start again.
    do_reset();
    count_cpu_rst_a(n);
    k = 0;
    while (running_a && k < 7) begin
      k++;
      pc_a = 32'(4 * (k - 1));
      if (k == 7) rst = 1'b1;
      @(negedge clk);
    end
    check("mid_rst_running", 64'(running_a), 64'd0);
    check("mid_rst_cpu_rst", 64'(cpu_rst_a), 64'd1);
    check("mid_rst_cnt",     64'(cycle_cnt_a), 64'd0);
    check("mid_rst_fpc",     64'(final_pc_a), 64'd0);
    check("mid_rst_done",    64'(done_a), 64'd0);
    rst = 1'b0;
    count_cpu_rst_a(n);
    check("mid_rst_restart_len", 64'(n), 64'(RST + 1));
    check("mid_rst_restart_run", 64'(running_a), 64'd1);

    // Manual-start instance: idles until start.
    do_reset();
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (cpu_rst_m && !running_m && !done_m) n++;
      @(negedge clk);
    end
    check("m_idle_100", 64'(n), 64'd100);
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    n = 0;
    while (cpu_rst_m && n < 60) begin
      n++;
      @(negedge clk);
    end
    check("m_reset_len", 64'(n), 64'(RST));
    check("m_running",   64'(running_m), 64'd1);
    k = 0;
    while (running_m && k < 100) begin
      k++;
      pc_m    = 32'h100 + 32'(4 * (k - 1));
      start_m = (k == 3);
      halt_m  = (k == 6);
      @(negedge clk);
    end
    start_m = 1'b0; halt_m = 1'b0;
    check("m1_done",    64'(done_m), 64'd1);
    check("m1_cnt",     64'(cycle_cnt_m), 64'd6);
    check("m1_timeout", 64'(timeout_m), 64'd0);
    check("m1_fpc",     64'(final_pc_m), 64'h114);

    // start from DONE clears the count and begins a fresh run.
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    check("m_restart_done",    64'(done_m), 64'd0);
    check("m_restart_cnt",     64'(cycle_cnt_m), 64'd0);
    check("m_restart_cpu_rst", 64'(cpu_rst_m), 64'd1);
    n = 0;
    while (cpu_rst_m && n < 60) begin
      n++;
      @(negedge clk);
    end
    check("m_restart_len", 64'(n), 64'(RST));
    k = 0;
    while (running_m && k < 100) begin
      k++;
      pc_m   = 32'h200 + 32'(4 * (k - 1));
      halt_m = (k == 8);
      @(negedge clk);
    end
    halt_m = 1'b0;
    check("m2_done",    64'(done_m), 64'd1);
    check("m2_cnt",     64'(cycle_cnt_m), 64'd8);
    check("m2_timeout", 64'(timeout_m), 64'd0);
    check("m2_fpc",     64'(final_pc_m), 64'h21C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
